str_byte_loader: RTL and testbench

//  Upstream feeder for the 128-bit string register. Accepts a byte stream over a valid/ready

---
 rtl/str_pkg.sv | 30 +++
 rtl/str_byte_loader.sv | 101 ++++++++++
 tb/tb_str_byte_loader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/str_pkg.sv
// rtl/str_pkg.sv - shared widths, terminator and state encoding for the string loader
//
// Purpose : constants shared by str_byte_loader and the 128-bit string register.
// Contents: WORD_WIDTH, STR_WIDTH, STR_BYTES, TERM_CHAR, counter width,
//           state encoding localparams and the loader state type.
package str_pkg;

  localparam int WORD_WIDTH = 8;
  localparam int STR_WIDTH  = 128;
  localparam int STR_BYTES  = STR_WIDTH / WORD_WIDTH;
  localparam int CNT_W      = 5;

  localparam logic [WORD_WIDTH-1:0] TERM_CHAR   = 8'h00;
  localparam logic [CNT_W-1:0]      STR_BYTES_C = CNT_W'(STR_BYTES);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_RECV  = 3'd2;
  localparam logic [2:0] ST_ALIGN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_RECV  = ST_RECV,
    S_ALIGN = ST_ALIGN,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/str_byte_loader.sv
// rtl/str_byte_loader.sv - byte-stream feeder building a right-aligned string in the string register
//
// Purpose : accepts characters over a valid/ready handshake and drives the string
//           register's clear / word_load / rshift controls so that, when done pulses,
//           char k sits in register byte k and all unused upper bytes are 0x00.
// Ports   : clk, rst_n (async active-low)
//           start                       begin a new string (sampled only in IDLE)
//           byte_in, byte_valid         incoming character stream
//           byte_ready                  high only in RECV
//           str_clr                     register clear (str_load with zero data)
//           word_out, word_load, rshift register word input and controls
//           busy                        high outside IDLE
//           done                        one-cycle completion pulse
//           len                         stored character count, 0..16
module str_byte_loader
  import str_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  str_clr,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_load,
  output logic                  rshift,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      len
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             xfer;
  logic             is_term;

  assign xfer    = (state == S_RECV) && byte_valid;
  assign is_term = (byte_in == TERM_CHAR);
  assign cnt_inc = cnt + CNT_W'(1);

  // Status and clear come straight off the state register.
  assign byte_ready = (state == S_RECV);
  assign str_clr    = (state == S_CLEAR);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign word_out   = byte_in;

  // A stored character is loaded into the register's top byte and shifted down in
  // the same cycle, so the string accumulates in the upper bytes; ALIGN then shifts
  // the remaining (16 - cnt) positions to bring char 0 down to byte 0.
  assign word_load = xfer && !is_term;
  assign rshift    = word_load || (state == S_ALIGN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      len   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CLEAR;
            cnt   <= '0;
          end
        end
        S_CLEAR: state <= S_RECV;
        S_RECV: begin
          if (xfer) begin
            if (!is_term) begin
              cnt <= cnt_inc;
              // Full string: already aligned, no ALIGN pass needed.
              if (cnt_inc == STR_BYTES_C) begin
                len   <= cnt_inc;
                state <= S_DONE;
              end
            end else begin
              len <= cnt;
              if (cnt == STR_BYTES_C) begin
                state <= S_DONE;
              end else begin
                // Counter is reused as the ALIGN down-counter: 16 - cnt shifts remain.
                cnt   <= STR_BYTES_C - cnt;
                state <= S_ALIGN;
              end
            end
          end
        end
        S_ALIGN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_str_byte_loader.sv
// tb/tb_str_byte_loader.sv - directed self-checking bench for str_byte_loader with a string register model
module tb_str_byte_loader;
  import str_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [WORD_WIDTH-1:0] byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  str_clr;
  logic [WORD_WIDTH-1:0] word_out;
  logic                  word_load;
  logic                  rshift;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      len;

  logic [STR_WIDTH-1:0]  str;
  int                    cyc;
  int                    n_done;
  int                    n_chk;
  int                    n_fail;

  str_byte_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .str_clr    (str_clr),
    .word_out   (word_out),
    .word_load  (word_load),
    .rshift     (rshift),
    .busy       (busy),
    .done       (done),
    .len        (len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 128-bit string register: clear, load-into-top-byte with shift right, plain shift right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         str <= '0;
    else if (str_clr)   str <= '0;
    else if (word_load) str <= {word_out, str[STR_WIDTH-1:WORD_WIDTH]};
    else if (rshift)    str <= {8'h00, str[STR_WIDTH-1:WORD_WIDTH]};
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) n_done <= n_done + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_str();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int xc);
    bit ok;
    ok = 1'b0;
    xc = 0;
    byte_in = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        ok = 1'b1;
        xc = cyc;
        break;
      end
    end
    if (!ok) check("xfer_timeout", 0, 1);
    @(posedge clk); #1 byte_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    bit ok;
    ok = 1'b0;
    dc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  int xc, dc, nd0;
  logic [7:0] seq4 [4];

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; n_done = 0;
    rst_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    seq4[0] = 8'h58; seq4[1] = 8'h59; seq4[2] = 8'h5A; seq4[3] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", byte_ready, 0);
    check("rst_done", done, 0);
    check("rst_len", len, 0);
    check("rst_ctl", {str_clr, word_load, rshift}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: "AB", TERM
    start_str();
    @(negedge clk);
    check("t1_clr", str_clr, 1);
    check("t1_clr_ready", byte_ready, 0);
    check("t1_busy", busy, 1);
    @(posedge clk); #1;
    send_byte(8'h41, xc);
    send_byte(8'h42, xc);
    send_byte(8'h00, xc);
    wait_done(dc);
    check("t1_latency", dc - xc, 15);
    check("t1_len", len, 2);
    check("t1_str", str, 128'h4241);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_idle", busy, 0);

    // 2: 16 chars, no TERM
    start_str();
    for (int i = 0; i < 16; i++) send_byte(8'h41 + 8'(i), xc);
    wait_done(dc);
    check("t2_latency", dc - xc, 1);
    check("t2_ready", byte_ready, 0);
    check("t2_len", len, 16);
    check("t2_str", str, 128'h504F4E4D4C4B4A494847464544434241);

    // 3: empty string
    start_str();
    send_byte(8'h00, xc);
    wait_done(dc);
    check("t3_latency", dc - xc, 17);
    check("t3_len", len, 0);
    check("t3_str", str, 128'h0);

    // 4: gaps in byte_valid with a non-zero byte on the bus
    start_str();
    for (int i = 0; i < 4; i++) begin
      byte_in = 8'h77; byte_valid = 1'b0;
      @(posedge clk); #1;
      send_byte(seq4[i], xc);
    end
    wait_done(dc);
    check("t4_latency", dc - xc, 14);
    check("t4_len", len, 3);
    check("t4_str", str, 128'h5A5958);

    // 5: async reset mid-string, then a clean string
    start_str();
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i), xc);
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_ready", byte_ready, 0);
    check("t5_len", len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_str();
    send_byte(8'h51, xc);
    send_byte(8'h00, xc);
    wait_done(dc);
    check("t5_len2", len, 1);
    check("t5_str2", str, 128'h51);

    // 6: start pulsed during RECV and ALIGN is ignored
    @(negedge clk);
    nd0 = n_done;
    start_str();
    start = 1'b1;
    send_byte(8'h41, xc);
    start = 1'b0;
    send_byte(8'h42, xc);
    send_byte(8'h00, xc);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(dc);
    check("t6_latency", dc - xc, 15);
    check("t6_str", str, 128'h4241);
    check("t6_len", len, 2);
    repeat (20) @(negedge clk);
    check("t6_done_count", n_done - nd0, 1);
    check("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
